// File: rtl/axis_bram_rowbuf_v2_0.sv
// ---------------------------------------------------------------------------
// axis_bram_rowbuf_v2_0
// AXI-Stream <-> wide-BRAM row adapter.
//   Write mode: packs DATA_WIDTH stream words into WORDS_PER_ROW-word rows and
//   commits each row to BRAM with a per-word write mask.
//   Read mode: fetches rows from BRAM (honouring RD_LATENCY) and unpacks them
//   onto the output stream.
//   A transfer is launched by a cfg_start pulse carrying mode, base row and
//   length in words.
//
// Ports
//   aclk, aresetn           clock (rising edge) / async active-low reset
//   cfg_start/mode/base/len transfer launch (sampled only while idle)
//   busy, done              status: not idle / one-cycle end-of-transfer pulse
//   err_short, err_wrap     sticky errors, cleared by the next accepted start
//   s_axis_*                write-mode input stream
//   m_axis_*                read-mode output stream
//   bram_en/we/addr/din     BRAM port, row-wide data
//   bram_dout               BRAM row read data
// ---------------------------------------------------------------------------
module axis_bram_rowbuf_v2_0 #(
  parameter int DATA_WIDTH    = 32,
  parameter int WORDS_PER_ROW = 36,
  parameter int ADDR_WIDTH    = 12,
  parameter int LEN_WIDTH     = 16,
  parameter int RD_LATENCY    = 1
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                cfg_start,
  input  logic                                cfg_mode,
  input  logic [ADDR_WIDTH-1:0]               cfg_base_addr,
  input  logic [LEN_WIDTH-1:0]                cfg_len,
  output logic                                busy,
  output logic                                done,
  output logic                                err_short,
  output logic                                err_wrap,
  input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic                                s_axis_tvalid,
  input  logic                                s_axis_tlast,
  output logic                                s_axis_tready,
  output logic [DATA_WIDTH-1:0]               m_axis_tdata,
  output logic                                m_axis_tvalid,
  output logic                                m_axis_tlast,
  input  logic                                m_axis_tready,
  output logic                                bram_en,
  output logic [WORDS_PER_ROW-1:0]            bram_we,
  output logic [ADDR_WIDTH-1:0]               bram_addr,
  output logic [DATA_WIDTH*WORDS_PER_ROW-1:0] bram_din,
  input  logic [DATA_WIDTH*WORDS_PER_ROW-1:0] bram_dout
);

  localparam int PTR_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(WORDS_PER_ROW - 1);
  localparam logic [1:0]       WAIT_LAST = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_FILL   = 3'd1,
    ST_WR_COMMIT = 3'd2,
    ST_RD_ISSUE  = 3'd3,
    ST_RD_WAIT   = 3'd4,
    ST_RD_DRAIN  = 3'd5,
    ST_DONE      = 3'd6
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [DATA_WIDTH-1:0]   buf_r [WORDS_PER_ROW];
  logic [WORDS_PER_ROW-1:0] mask_r;
  logic [PTR_W-1:0]        ptr_r;
  logic [LEN_WIDTH-1:0]    cnt_r;
  logic [LEN_WIDTH-1:0]    len_r;
  logic [ADDR_WIDTH-1:0]   row_r;
  logic [1:0]              wait_cnt_r;
  logic                    finish_r;
  logic                    err_short_r;
  logic                    err_wrap_r;

  logic [LEN_WIDTH-1:0]    cnt_inc_s;
  logic                    wr_row_end_s;
  logic                    wr_finish_s;

  assign cnt_inc_s    = cnt_r + LEN_WIDTH'(1);
  // A write row closes on a full row, on the final counted beat, or on tlast.
  assign wr_finish_s  = (cnt_inc_s == len_r) || s_axis_tlast;
  assign wr_row_end_s = (ptr_r == PTR_LAST) || wr_finish_s;

  assign busy      = (state_r != ST_IDLE);
  assign err_short = err_short_r;
  assign err_wrap  = err_wrap_r;

  // Row write data: only masked words carry buffer contents, the rest read 0.
  for (genvar gi = 0; gi < WORDS_PER_ROW; gi++) begin : g_din
    assign bram_din[gi*DATA_WIDTH +: DATA_WIDTH] =
      ((state_r == ST_WR_COMMIT) && mask_r[gi]) ? buf_r[gi] : '0;
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt_s   = state_r;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    bram_en       = 1'b0;
    bram_we       = '0;
    bram_addr     = '0;
    done          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_len == '0) begin
            state_nxt_s = ST_DONE;
          end else if (cfg_mode) begin
            state_nxt_s = ST_RD_ISSUE;
          end else begin
            state_nxt_s = ST_WR_FILL;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_FILL: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && wr_row_end_s) begin
          state_nxt_s = ST_WR_COMMIT;
        end else begin
          state_nxt_s = ST_WR_FILL;
        end
      end
      ST_WR_COMMIT: begin
        bram_en   = 1'b1;
        bram_we   = mask_r;
        bram_addr = row_r;
        if (finish_r) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_WR_FILL;
        end
      end
      ST_RD_ISSUE: begin
        bram_en     = 1'b1;
        bram_addr   = row_r;
        state_nxt_s = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = ST_RD_DRAIN;
        end else begin
          state_nxt_s = ST_RD_WAIT;
        end
      end
      ST_RD_DRAIN: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = buf_r[ptr_r];
        m_axis_tlast  = (cnt_r == (len_r - LEN_WIDTH'(1)));
        if (m_axis_tready) begin
          if (cnt_inc_s == len_r) begin
            state_nxt_s = ST_DONE;
          end else if (ptr_r == PTR_LAST) begin
            state_nxt_s = ST_RD_ISSUE;
          end else begin
            state_nxt_s = ST_RD_DRAIN;
          end
        end else begin
          state_nxt_s = ST_RD_DRAIN;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: row buffer, mask, pointers, row address and sticky errors.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < WORDS_PER_ROW; i++) begin
        buf_r[i] <= '0;
      end
      mask_r      <= '0;
      ptr_r       <= '0;
      cnt_r       <= '0;
      len_r       <= '0;
      row_r       <= '0;
      wait_cnt_r  <= 2'd0;
      finish_r    <= 1'b0;
      err_short_r <= 1'b0;
      err_wrap_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cfg_start) begin
            len_r       <= cfg_len;
            row_r       <= cfg_base_addr;
            ptr_r       <= '0;
            cnt_r       <= '0;
            mask_r      <= '0;
            finish_r    <= 1'b0;
            err_short_r <= 1'b0;
            err_wrap_r  <= 1'b0;
          end
        end
        ST_WR_FILL: begin
          if (s_axis_tvalid) begin
            buf_r[ptr_r]  <= s_axis_tdata;
            mask_r[ptr_r] <= 1'b1;
            ptr_r         <= ptr_r + PTR_W'(1);
            cnt_r         <= cnt_inc_s;
            finish_r      <= wr_finish_s;
            if (s_axis_tlast && (cnt_inc_s < len_r)) begin
              err_short_r <= 1'b1;
            end
          end
        end
        ST_WR_COMMIT: begin
          row_r  <= row_r + ADDR_WIDTH'(1);
          ptr_r  <= '0;
          mask_r <= '0;
          // Wrap only matters if another row follows in this transfer.
          if (!finish_r && (row_r == '1)) begin
            err_wrap_r <= 1'b1;
          end
        end
        ST_RD_ISSUE: begin
          wait_cnt_r <= 2'd0;
        end
        ST_RD_WAIT: begin
          wait_cnt_r <= wait_cnt_r + 2'd1;
          if (wait_cnt_r == WAIT_LAST) begin
            for (int i = 0; i < WORDS_PER_ROW; i++) begin
              buf_r[i] <= bram_dout[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
        ST_RD_DRAIN: begin
          if (m_axis_tready) begin
            cnt_r <= cnt_inc_s;
            if ((cnt_inc_s != len_r) && (ptr_r == PTR_LAST)) begin
              row_r <= row_r + ADDR_WIDTH'(1);
              ptr_r <= '0;
              if (row_r == '1) begin
                err_wrap_r <= 1'b1;
              end
            end else begin
              ptr_r <= ptr_r + PTR_W'(1);
            end
          end
        end
        ST_DONE: begin
          finish_r <= 1'b0;
        end
        default: begin
          ptr_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_bram_rowbuf_v2_0.sv
// Directed self-checking bench for axis_bram_rowbuf_v2_0 (W=32, WPR=4,
// ADDR_WIDTH=12, RD_LATENCY=2). Inputs change on the falling edge, outputs
// are sampled on the falling edge.
module tb_axis_bram_rowbuf_v2_0;

  logic          aclk;
  logic          aresetn;
  logic          cfg_start;
  logic          cfg_mode;
  logic [11:0]   cfg_base_addr;
  logic [15:0]   cfg_len;
  logic          busy;
  logic          done;
  logic          err_short;
  logic          err_wrap;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [11:0]   bram_addr;
  logic [127:0]  bram_din;
  logic [127:0]  bram_dout;

  int checks   = 0;
  int failures = 0;

  axis_bram_rowbuf_v2_0 #(
    .DATA_WIDTH(32), .WORDS_PER_ROW(4), .ADDR_WIDTH(12),
    .LEN_WIDTH(16), .RD_LATENCY(2)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .cfg_base_addr(cfg_base_addr), .cfg_len(cfg_len),
    .busy(busy), .done(done), .err_short(err_short), .err_wrap(err_wrap),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Read-only BRAM model: row a, word i holds 32'h5000_0000 + (a<<8) + i.
  function automatic logic [127:0] rom_row(input logic [11:0] a);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = 32'h5000_0000 + ({20'h0, a} << 8) + i;
    return r;
  endfunction

  logic [127:0] rd_pipe = 128'h0;
  initial bram_dout = 128'h0;
  // Two-cycle read pipeline.
  always @(posedge aclk) begin
    if (bram_en) rd_pipe <= rom_row(bram_addr);
    bram_dout <= rd_pipe;
  end

  // Commit / enable / done monitor.
  logic [11:0]  com_addr [0:31];
  logic [3:0]   com_we   [0:31];
  logic [127:0] com_din  [0:31];
  int com_n    = 0;
  int en_cnt   = 0;
  int done_cnt = 0;
  always @(negedge aclk) begin
    if (bram_en) en_cnt <= en_cnt + 1;
    if (bram_en && (bram_we != 4'h0) && (com_n < 32)) begin
      com_addr[com_n] <= bram_addr;
      com_we[com_n]   <= bram_we;
      com_din[com_n]  <= bram_din;
      com_n           <= com_n + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic mode, input logic [11:0] base, input logic [15:0] len);
    @(negedge aclk);
    cfg_start = 1'b1; cfg_mode = mode; cfg_base_addr = base; cfg_len = len;
    @(negedge aclk);
    cfg_start = 1'b0; cfg_mode = 1'b0; cfg_base_addr = 12'h0; cfg_len = 16'h0;
  endtask

  // Offers n_offer beats (dbase+k), tlast on beat last_idx, until done.
  task automatic wr_stream(input logic [31:0] dbase, input int n_offer, input int last_idx,
                           output int accepted, output logic saw_done);
    accepted = 0;
    saw_done = 1'b0;
    for (int cyc = 0; cyc < 100 && !saw_done; cyc++) begin
      @(negedge aclk);
      if (done) saw_done = 1'b1;
      if (accepted < n_offer) begin
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = dbase + 32'(accepted);
        s_axis_tlast  = (accepted == last_idx);
      end else begin
        s_axis_tvalid = 1'b0; s_axis_tdata = 32'h0; s_axis_tlast = 1'b0;
      end
      if (s_axis_tvalid && s_axis_tready) accepted++;
    end
    @(negedge aclk);
  endtask

  int          acc;
  logic        sd;
  int          c0, d0, e0;
  logic [31:0] rx_data [0:7];
  logic        rx_last [0:7];
  int          rx_n;
  logic        stall_pending;
  logic [31:0] stall_data;
  logic        stall_last;

  initial begin
    aresetn = 1'b1; cfg_start = 1'b0; cfg_mode = 1'b0; cfg_base_addr = 12'h0; cfg_len = 16'h0;
    s_axis_tdata = 32'h0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    #2 aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tready", s_axis_tready, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_en", bram_en, 1'b0);
    check("rst_we", bram_we, 4'h0);
    check("rst_errs", {err_short, err_wrap}, 2'b00);
    aresetn = 1'b1;
    @(negedge aclk);

    // 1: two full rows at 5 and 6
    c0 = com_n; d0 = done_cnt;
    start(1'b0, 12'd5, 16'd8);
    check("t1_busy", busy, 1'b1);
    wr_stream(32'hA1A1_0000, 8, -1, acc, sd);
    check("t1_done_seen", sd, 1'b1);
    check("t1_accepted", acc, 8);
    check("t1_commits", com_n - c0, 2);
    check("t1_addr0", com_addr[c0], 12'd5);
    check("t1_we0", com_we[c0], 4'hF);
    check("t1_din0", com_din[c0], 128'hA1A10003_A1A10002_A1A10001_A1A10000);
    check("t1_addr1", com_addr[c0+1], 12'd6);
    check("t1_we1", com_we[c0+1], 4'hF);
    check("t1_din1", com_din[c0+1], 128'hA1A10007_A1A10006_A1A10005_A1A10004);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_errs", {err_short, err_wrap}, 2'b00);
    check("t1_busy_end", busy, 1'b0);

    // 2: len 6 leaves a half row; 7th beat refused
    c0 = com_n;
    start(1'b0, 12'd20, 16'd6);
    wr_stream(32'hB2B2_0000, 7, -1, acc, sd);
    check("t2_done_seen", sd, 1'b1);
    check("t2_accepted", acc, 6);
    check("t2_tready_after", s_axis_tready, 1'b0);
    check("t2_commits", com_n - c0, 2);
    check("t2_din0", com_din[c0], 128'hB2B20003_B2B20002_B2B20001_B2B20000);
    check("t2_addr1", com_addr[c0+1], 12'd21);
    check("t2_we1", com_we[c0+1], 4'b0011);
    check("t2_din1", com_din[c0+1], 128'h00000000_00000000_B2B20005_B2B20004);
    s_axis_tvalid = 1'b0;

    // 3: early tlast on beat index 2
    c0 = com_n; d0 = done_cnt;
    start(1'b0, 12'd40, 16'd8);
    wr_stream(32'hC3C3_0000, 3, 2, acc, sd);
    check("t3_done_seen", sd, 1'b1);
    check("t3_accepted", acc, 3);
    check("t3_commits", com_n - c0, 1);
    check("t3_addr", com_addr[c0], 12'd40);
    check("t3_we", com_we[c0], 4'b0111);
    check("t3_din", com_din[c0], 128'h00000000_C3C30002_C3C30001_C3C30000);
    check("t3_err_short", err_short, 1'b1);
    check("t3_done_cnt", done_cnt - d0, 1);

    // 5: row address wrap 4095 -> 0; err_short cleared by the new start
    c0 = com_n;
    start(1'b0, 12'd4095, 16'd8);
    check("t5_err_short_clr", err_short, 1'b0);
    wr_stream(32'hE5E5_0000, 8, -1, acc, sd);
    check("t5_done_seen", sd, 1'b1);
    check("t5_commits", com_n - c0, 2);
    check("t5_addr0", com_addr[c0], 12'd4095);
    check("t5_addr1", com_addr[c0+1], 12'd0);
    check("t5_din1", com_din[c0+1], 128'hE5E50007_E5E50006_E5E50005_E5E50004);
    check("t5_err_wrap", err_wrap, 1'b1);

    // 4: read base 2 len 5 with tready toggling
    start(1'b1, 12'd2, 16'd5);
    check("t4_err_wrap_clr", err_wrap, 1'b0);
    rx_n = 0; sd = 1'b0; stall_pending = 1'b0; stall_data = 32'h0; stall_last = 1'b0;
    for (int cyc = 0; cyc < 200 && !sd; cyc++) begin
      @(negedge aclk);
      if (done) sd = 1'b1;
      if (stall_pending) begin
        check("t4_stall_valid", m_axis_tvalid, 1'b1);
        check("t4_stall_data", m_axis_tdata, stall_data);
        check("t4_stall_last", m_axis_tlast, stall_last);
      end
      m_axis_tready = (cyc % 2 == 0);
      if (m_axis_tvalid && m_axis_tready) begin
        if (rx_n < 8) begin
          rx_data[rx_n] = m_axis_tdata;
          rx_last[rx_n] = m_axis_tlast;
        end
        rx_n++;
        stall_pending = 1'b0;
      end else if (m_axis_tvalid) begin
        stall_pending = 1'b1; stall_data = m_axis_tdata; stall_last = m_axis_tlast;
      end else begin
        stall_pending = 1'b0;
      end
    end
    m_axis_tready = 1'b0;
    @(negedge aclk);
    check("t4_done_seen", sd, 1'b1);
    check("t4_rx_n", rx_n, 5);
    check("t4_w0", rx_data[0], 32'h5000_0200);
    check("t4_w1", rx_data[1], 32'h5000_0201);
    check("t4_w2", rx_data[2], 32'h5000_0202);
    check("t4_w3", rx_data[3], 32'h5000_0203);
    check("t4_w4", rx_data[4], 32'h5000_0300);
    check("t4_last", {rx_last[0], rx_last[1], rx_last[2], rx_last[3], rx_last[4]}, 5'b00001);
    check("t4_tvalid_end", m_axis_tvalid, 1'b0);

    // zero-length transfer: straight to done, no BRAM access
    e0 = en_cnt;
    start(1'b0, 12'd7, 16'd0);
    check("t0_done", done, 1'b1);
    check("t0_busy", busy, 1'b1);
    @(negedge aclk);
    check("t0_done_end", done, 1'b0);
    check("t0_busy_end", busy, 1'b0);
    check("t0_no_en", en_cnt - e0, 0);

    // 6: reset in the middle of a write fill
    c0 = com_n;
    start(1'b0, 12'd100, 16'd8);
    acc = 0;
    for (int cyc = 0; cyc < 20 && acc < 2; cyc++) begin
      @(negedge aclk);
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD_0000 + 32'(acc); s_axis_tlast = 1'b0;
      if (s_axis_tready) acc++;
    end
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    e0 = en_cnt;
    aresetn = 1'b0;
    #1;
    check("t6_busy", busy, 1'b0);
    check("t6_tready", s_axis_tready, 1'b0);
    check("t6_en", bram_en, 1'b0);
    check("t6_we", bram_we, 4'h0);
    check("t6_addr", bram_addr, 12'h0);
    check("t6_din", bram_din, 128'h0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("t6_no_en", en_cnt - e0, 0);
    check("t6_no_commit", com_n - c0, 0);
    check("t6_idle", busy, 1'b0);
    start(1'b0, 12'd200, 16'd4);
    wr_stream(32'hF6F6_0000, 4, -1, acc, sd);
    check("t6_done_seen", sd, 1'b1);
    check("t6_commits", com_n - c0, 1);
    check("t6_addr_new", com_addr[c0], 12'd200);
    check("t6_din_new", com_din[c0], 128'hF6F60003_F6F60002_F6F60001_F6F60000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
